nios_system_keys_ctrl: RTL and testbench

//  Avalon-MM slave front-end for the board push-buttons. Synchronises and

---
 rtl/nios_system_keys_ctrl.sv | 159 +++++++++++++++
 tb/tb_nios_system_keys_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_keys_ctrl.sv
// nios_system_keys_ctrl: Avalon-MM slave for the board push-buttons.
// Synchronises and debounces the raw key pins, captures press edges into a
// W1C register and raises a maskable level interrupt.
// Optional build macro KEYS_CTRL_EVCNT_EN adds a 16-bit event counter at
// address 3; without it address 3 reads 0 and carries no logic.
module nios_system_keys_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 50000,
  parameter bit EDGE_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // A counter at this value with a still-differing input completes the run.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d, db_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d, edge_set;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  // Upper writedata bits are only meaningful for wider key sets.
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce counter: runs while the synced level disagrees with the
  // debounced level and flips the debounced level after DB_CYCLES in a row.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
      logic [CW-1:0] cnt_q, cnt_d;
      logic          bit_d;

      // Next count and debounced bit for this key.
      always_comb begin
        cnt_d = '0;
        bit_d = db_q[gi];
        if (sync2_q[gi] != db_q[gi]) begin
          if (cnt_q == CNT_LAST) begin
            bit_d = ~db_q[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Counter state.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      assign db_d[gi] = bit_d;
    end
  endgenerate

  // Debounced levels and their one-cycle-old copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q      <= '1;
      db_prev_q <= '1;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  // Capture the selected transition of each debounced bit.
  assign edge_set = EDGE_POL ? (db_q & ~db_prev_q) : (db_prev_q & ~db_q);

  // MASK write and EDGE W1C; a capture in the same cycle beats the clear.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q | edge_set;
    if (wr_en && address == 2'd1) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd2) edge_d = (edge_q & ~writedata[WIDTH-1:0]) | edge_set;
  end

  // MASK and EDGE registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

`ifdef KEYS_CTRL_EVCNT_EN
  logic [15:0] evcnt_q, evcnt_d;
  logic        ev_new;

  // An event is any EDGE bit going from 0 to 1.
  assign ev_new = |(edge_set & ~edge_q);

  // Saturating event count; a clear that coincides with an event leaves 1.
  always_comb begin
    evcnt_d = evcnt_q;
    if (wr_en && address == 2'd3) begin
      evcnt_d = {15'd0, ev_new};
    end else if (ev_new && evcnt_q != 16'hFFFF) begin
      evcnt_d = evcnt_q + 16'd1;
    end
  end

  // Event counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) evcnt_q <= '0;
    else          evcnt_q <= evcnt_d;
  end
`endif

  // Read mux, evaluated every cycle; reads carry no side effects.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: readdata_d[WIDTH-1:0] = db_q;
      2'd1: readdata_d[WIDTH-1:0] = mask_q;
      2'd2: readdata_d[WIDTH-1:0] = edge_q;
`ifdef KEYS_CTRL_EVCNT_EN
      2'd3: readdata_d[15:0] = evcnt_q;
`endif
      default: readdata_d = '0;
    endcase
  end

  // Registered read data gives a fixed one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_system_keys_ctrl.sv
// Scoreboard bench for nios_system_keys_ctrl (WIDTH=4, DB_CYCLES=4,
// EDGE_POL=0). The driver pushes the expected read data and irq for every
// cycle; a monitor pops and compares just after each rising edge.
module tb_nios_system_keys_ctrl;
  localparam int W  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [W-1:0] in_port = '1;
  wire  [31:0]  readdata;
  wire          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_keys_ctrl #(.WIDTH(W), .DB_CYCLES(DB), .EDGE_POL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } txn_t;
  txn_t sb[$];

  // Reference model: key samples reach the debouncer two edges late; a level
  // flips after DB disagreeing samples in a row; a fall is captured one edge
  // after the debounced level drops.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_db, m_dbp, m_edge, m_mask;
  int           m_run[W];
  int           m_ev;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_db};
      2'd1: return {28'd0, m_mask};
      2'd2: return {28'd0, m_edge};
`ifdef KEYS_CTRL_EVCNT_EN
      default: return m_ev;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    m_hist.delete();
    m_hist.push_back('1);
    m_hist.push_back('1);
    m_db = '1; m_dbp = '1; m_edge = '0; m_mask = '0; m_ev = 0;
    for (int k = 0; k < W; k++) m_run[k] = 0;
  endtask

  task automatic m_step(input logic [W-1:0] keys, input bit wr, input logic [1:0] a,
                        input logic [31:0] wd);
    logic [W-1:0] s, fell, newly;
    s     = m_hist.pop_front();
    m_hist.push_back(keys);
    fell  = m_dbp & ~m_db;
    newly = fell & ~m_edge;
    if (wr && a == 2'd1) m_mask = wd[W-1:0];
    if (wr && a == 2'd2) m_edge = (m_edge & ~wd[W-1:0]) | fell;
    else                 m_edge = m_edge | fell;
    if (wr && a == 2'd3)            m_ev = (newly != 0) ? 1 : 0;
    else if (newly != 0 && m_ev < 65535) m_ev = m_ev + 1;
    m_dbp = m_db;
    for (int k = 0; k < W; k++) begin
      if (s[k] != m_db[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == DB) begin
          m_db[k]  = ~m_db[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  // One bus cycle: drive, predict, push.
  task automatic cyc(input logic [W-1:0] keys, input bit cs, input bit wn,
                     input logic [1:0] a, input logic [31:0] wd, input string name,
                     input bit use_const, input logic [31:0] cval);
    txn_t t;
    @(negedge clk);
    in_port = keys; chipselect = cs; write_n = wn; address = a; writedata = wd;
    t.addr = a;
    t.name = name;
    t.rd   = use_const ? cval : m_read(a);
    m_step(keys, cs & ~wn, a, wd);
    t.irq  = |(m_edge & m_mask);
    sb.push_back(t);
    if (cs && !wn) $display("write addr=%0d data=%h keys=%h", a, wd, keys);
  endtask

  task automatic idle(input logic [W-1:0] keys, input int n);
    for (int i = 0; i < n; i++) cyc(keys, 1'b0, 1'b1, 2'(i), 32'd0, "", 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [W-1:0] keys, input logic [1:0] a, input logic [31:0] d);
    cyc(keys, 1'b1, 1'b0, a, d, "", 1'b0, 32'd0);
  endtask

  task automatic rd_const(input logic [W-1:0] keys, input logic [1:0] a,
                          input logic [31:0] v, input string name);
    cyc(keys, 1'b1, 1'b1, a, 32'd0, name, 1'b1, v);
  endtask

  // Monitor: compare the oldest expectation just after each rising edge.
  txn_t mt;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mt = sb.pop_front();
      checks++;
      if (readdata !== mt.rd) begin
        errors++;
        $display("FAIL rd_%s addr=%0d readdata=%h expected=%h", mt.name, mt.addr, readdata, mt.rd);
      end
      checks++;
      if (irq !== mt.irq) begin
        errors++;
        $display("FAIL irq_%s irq=%b expected=%b", mt.name, irq, mt.irq);
      end
      if (mt.name != "")
        $display("txn %s addr=%0d readdata=%h irq=%b", mt.name, mt.addr, readdata, irq);
    end
  end

  logic [W-1:0] keys;
  int           hold;
  bit           found;
  int           r;

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_state readdata=%h irq=%b expected=00000000 0", readdata, irq);
    end
    reset_n = 1'b1;

    // 1: reset values.
    rd_const(4'hF, 2'd0, 32'hF, "reset_data");
    rd_const(4'hF, 2'd1, 32'h0, "reset_mask");
    rd_const(4'hF, 2'd2, 32'h0, "reset_edge");

    // 2: glitch shorter than the debounce window.
    idle(4'hE, 3);
    idle(4'hF, 8);
    rd_const(4'hF, 2'd0, 32'hF, "glitch_data");
    rd_const(4'hF, 2'd2, 32'h0, "glitch_edge");

    // 3: held press, then mask and W1C.
    idle(4'hE, 10);
    rd_const(4'hE, 2'd0, 32'hE, "press_data");
    rd_const(4'hE, 2'd2, 32'h1, "press_edge");
    wr(4'hE, 2'd1, 32'h1);
    rd_const(4'hE, 2'd1, 32'h1, "mask_rb");
    wr(4'hE, 2'd2, 32'h1);
    rd_const(4'hE, 2'd2, 32'h0, "w1c_edge");

    // 4: capture and W1C of the same bit in one cycle.
    wr(4'hE, 2'd1, 32'h4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_dbp[2] && !m_db[2]) begin
        wr(4'hA, 2'd2, 32'h4);
        found = 1'b1;
      end else begin
        idle(4'hA, 1);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL key2_capture_wait waited=20 cycles required=capture");
    end
    rd_const(4'hA, 2'd2, 32'h4, "set_wins_edge");

    // 5: release; rising edges are not captured.
    idle(4'hF, 10);
    rd_const(4'hF, 2'd0, 32'hF, "release_data");
    rd_const(4'hF, 2'd2, 32'h4, "release_edge");

    // 6: event counter.
    wr(4'hF, 2'd2, 32'hF);
    wr(4'hF, 2'd3, 32'h0);
    idle(4'h5, 10);
`ifdef KEYS_CTRL_EVCNT_EN
    rd_const(4'h5, 2'd3, 32'h1, "evcnt_two_keys");
`else
    rd_const(4'h5, 2'd3, 32'h0, "evcnt_absent");
`endif
    wr(4'h5, 2'd3, 32'h0);
    rd_const(4'h5, 2'd3, 32'h0, "evcnt_cleared");

    // Randomised traffic against the model.
    keys = 4'h5;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        keys = keys ^ 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 10);
      end
      hold--;
      r = $urandom_range(0, 9);
      if (r < 3)
        cyc(keys, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, "", 1'b0, 32'd0);
      else if (r == 3)
        cyc(keys, 1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom, "", 1'b0, 32'd0);
      else
        cyc(keys, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom, "", 1'b0, 32'd0);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    // Asynchronous reset must clear outputs without a clock edge.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset readdata=%h irq=%b expected=00000000 0", readdata, irq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
